// File: rtl/frame_pixel_fetcher.sv
// Streams a frame region out of the 128b frame RAM (port b) as 8-bit pixels.
// Credit-limited read issue, word FIFO, byte serializer with sof/eof tags.
module frame_pixel_fetcher #(
  parameter logic [18:0] BASE_ADDR    = 19'h00000,
  parameter int          FRAME_BYTES  = 307200,
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic [18:0]  address_b,
  input  logic [127:0] data_out_b,
  output logic [7:0]   pixel_data,
  output logic         pixel_valid,
  input  logic         pixel_ready,
  output logic         pixel_sof,
  output logic         pixel_eof,
  output logic         busy
);

  localparam int          WORDS = FRAME_BYTES / 16;
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST  = 15'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state;
  logic [14:0]             word_cnt;
  logic [14:0]             load_widx;
  logic [14:0]             ser_widx;
  logic [READ_LATENCY-1:0] pipe;
  logic [127:0]            fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             fifo_count;
  logic [127:0]            ser_word;
  logic [3:0]              byte_idx;
  logic                    issue;
  logic                    fifo_wr;
  logic                    ser_load;
  logic                    accept;
  int                      inflight;

  // Credits cover FIFO entries plus reads still in the RAM pipe.
  always_comb begin
    inflight = $countones(pipe);
    issue    = (state == FETCH) &&
               (int'(fifo_count) + inflight < FIFO_DEPTH);
    fifo_wr  = pipe[READ_LATENCY-1];
    accept   = pixel_valid & pixel_ready;
    ser_load = (fifo_count != '0) &&
               (!pixel_valid || (accept && byte_idx == 4'd15));
  end

  assign pixel_data = ser_word[{byte_idx, 3'b000} +: 8];
  assign pixel_sof  = pixel_valid && byte_idx == 4'd0 &&
                      ser_widx == 15'd0;
  assign pixel_eof  = pixel_valid && byte_idx == 4'd15 &&
                      ser_widx == LAST;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      address_b <= BASE_ADDR;
      word_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state     <= FETCH;
            address_b <= BASE_ADDR;
            word_cnt  <= '0;
          end
        end
        FETCH: begin
          if (issue) begin
            if (word_cnt == LAST) begin
              address_b <= BASE_ADDR;
              word_cnt  <= '0;
              if (!enable) state <= DRAIN;
            end else begin
              address_b <= address_b + 19'd16;
              word_cnt  <= word_cnt + 15'd1;
            end
          end
        end
        DRAIN: begin
          if (pipe == '0 && fifo_count == '0 && !pixel_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pipe <= READ_LATENCY'({pipe, issue});
      if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (ser_load) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(fifo_wr)
                               - (AW+1)'(ser_load);
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= data_out_b;
  end

  // Words leave the FIFO in frame order, so a load counter tags them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ser_word    <= '0;
      byte_idx    <= '0;
      pixel_valid <= 1'b0;
      ser_widx    <= '0;
      load_widx   <= '0;
    end else if (ser_load) begin
      ser_word    <= fifo_mem[rd_ptr];
      byte_idx    <= '0;
      pixel_valid <= 1'b1;
      ser_widx    <= load_widx;
      load_widx   <= (load_widx == LAST) ? '0
                                         : load_widx + 15'd1;
    end else if (accept) begin
      byte_idx <= byte_idx + 4'd1;
      if (byte_idx == 4'd15) pixel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_pixel_fetcher.sv
// Directed bench for frame_pixel_fetcher with a 64-byte frame.
// RAM model returns byte (addr - BASE) at every byte address.
module tb_frame_pixel_fetcher;

  localparam logic [18:0] BASE = 19'h00040;
  localparam int          FB   = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [18:0]  address_b;
  logic [127:0] data_out_b;
  logic [7:0]   pixel_data;
  logic         pixel_valid;
  logic         pixel_ready;
  logic         pixel_sof;
  logic         pixel_eof;
  logic         busy;

  int passed = 0;
  int total  = 0;

  logic [9:0]  got [$];
  int          issues = 0;
  logic [18:0] prev_addr = BASE;
  logic        addr_bad = 1'b0;
  logic [18:0] ra = '0;

  frame_pixel_fetcher #(
    .BASE_ADDR(BASE),
    .FRAME_BYTES(FB),
    .READ_LATENCY(2),
    .FIFO_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .address_b(address_b),
    .data_out_b(data_out_b),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_sof(pixel_sof),
    .pixel_eof(pixel_eof),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Two register stages: address in cycle C gives data in cycle C+2.
  always @(posedge clock) begin
    ra <= address_b;
    for (int i = 0; i < 16; i++)
      data_out_b[i*8 +: 8] <= 8'(int'(ra) - int'(BASE) + i);
  end

  always @(negedge clock) begin
    if (reset) begin
      got.delete();
      issues    = 0;
      prev_addr = address_b;
    end else begin
      if (address_b != prev_addr) issues++;
      prev_addr = address_b;
      if (address_b[3:0] != 4'd0) addr_bad = 1'b1;
      if (pixel_valid && pixel_ready)
        got.push_back({pixel_sof, pixel_eof, pixel_data});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Pixel k of the stream must be byte k%64 of the frame.
  task automatic check_stream(input string tag);
    logic [9:0] e;
    for (int k = 0; k < got.size(); k++) begin
      e = {k % FB == 0, k % FB == FB - 1, 8'(k % FB)};
      total++;
      assert (got[k] === e) passed++;
      else begin
        $error("FAIL %s pixel %0d observed=%0h expected=%0h",
               tag, k, got[k], e);
        break;
      end
    end
  endtask

  initial begin
    int n;
    int sofs;
    int eofs;
    reset       = 1'b1;
    enable      = 1'b0;
    pixel_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", pixel_valid, 0);
    chk("rst_sof", pixel_sof, 0);
    chk("rst_eof", pixel_eof, 0);
    chk("rst_data", pixel_data, 0);
    chk("rst_addr", address_b, BASE);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // First frame latency and address sequence
    pixel_ready = 1'b1;
    enable      = 1'b1;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_addr0", address_b, BASE);
    tick();
    chk("t1_addr1", address_b, BASE + 19'd16);
    chk("t1_v2", pixel_valid, 0);
    tick();
    chk("t1_addr2", address_b, BASE + 19'd32);
    chk("t1_v3", pixel_valid, 0);
    tick();
    chk("t1_addr3", address_b, BASE + 19'd48);
    chk("t1_v4", pixel_valid, 0);
    tick();
    chk("t1_wrap", address_b, BASE);
    chk("t1_v5", pixel_valid, 1);
    chk("t1_data", pixel_data, 0);
    chk("t1_sof", pixel_sof, 1);

    // Stop request while fetching word 2
    for (int i = 0; i < 400 && got.size() < 140; i++) tick();
    chk("t2_len", got.size() >= 140, 1);
    for (int i = 0; i < 100 && address_b != BASE + 19'd32; i++)
      tick();
    chk("t4_word2", address_b, BASE + 19'd32);
    enable = 1'b0;
    for (int i = 0; i < 600 && busy; i++) tick();
    chk("t4_idle", busy, 0);
    check_stream("t2_stream");
    chk("t4_whole", got.size() % FB, 0);
    chk("t4_last_eof", got[got.size()-1][8], 1);
    n = got.size();
    repeat (20) tick();
    chk("t4_no_more", got.size(), n);
    chk("t4_valid", pixel_valid, 0);
    chk("t4_addr", address_b, BASE);

    // Indefinite stall: only the credit window gets fetched
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    pixel_ready = 1'b0;
    enable      = 1'b1;
    repeat (200) tick();
    chk("t3_issues", issues, 9);
    chk("t3_valid", pixel_valid, 1);
    chk("t3_data", pixel_data, 0);
    chk("t3_sof", pixel_sof, 1);
    chk("t3_none", got.size(), 0);

    // Random ready over at least three frames
    for (int i = 0; i < 6000 && got.size() < 3 * FB; i++) begin
      pixel_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t5_len", got.size() >= 3 * FB, 1);
    enable = 1'b0;
    for (int i = 0; i < 3000 && busy; i++) begin
      pixel_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t5_idle", busy, 0);
    check_stream("t5_stream");
    chk("t5_whole", got.size() % FB, 0);
    sofs = 0;
    eofs = 0;
    foreach (got[k]) begin
      if (got[k][9]) sofs++;
      if (got[k][8]) eofs++;
    end
    chk("t5_sofs", sofs, got.size() / FB);
    chk("t5_eofs", eofs, got.size() / FB);

    // Reset in the middle of a frame
    pixel_ready = 1'b1;
    enable      = 1'b1;
    for (int i = 0; i < 20 && !pixel_valid; i++) tick();
    repeat (10) tick();
    chk("t6_pre", pixel_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_valid", pixel_valid, 0);
    chk("t6_addr", address_b, BASE);
    chk("t6_busy", busy, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 300 && got.size() < 70; i++) tick();
    chk("t6_len", got.size() >= 70, 1);
    check_stream("t6_stream");
    enable = 1'b0;
    for (int i = 0; i < 600 && busy; i++) tick();
    chk("t6_idle", busy, 0);
    chk("addr_align", addr_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
